filter_channel_scheduler: RTL and testbench

//  Shares one moving-average datapath among N_CH ADC channels of the muon front-end.

---
 rtl/filter_channel_scheduler.sv | 170 +++++++++++++++++
 tb/tb_filter_channel_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_channel_scheduler.sv
// filter_channel_scheduler
//   Round-robin shares one moving-average datapath among N_CH ADC channels.
//   Each accepted sample updates that channel's window history and running sum,
//   and produces a channel-tagged, truncated window average.
//   Two-stage pipeline: the grant cycle captures the sample and the history slot
//   it replaces (S1). The next edge commits the state and registers the result.
//   Optional build macro WARMUP_MASK_EN: suppresses results until a channel's
//   window has filled (the state still updates).
module filter_channel_scheduler #(
    parameter int N_CH   = 4,
    parameter int DW     = 14,
    parameter int WINDOW = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*DW-1:0]      in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [N_CH-1:0]         ch_clear,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(N_CH)-1:0] out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CW = $clog2(N_CH);
    localparam int PW = $clog2(WINDOW);
    localparam int SW = DW + $clog2(WINDOW);

    // Per-channel window state
    logic [DW-1:0] hist [N_CH][WINDOW];
    logic [SW-1:0] sum  [N_CH];
    logic [PW-1:0] wptr [N_CH];

    // Arbiter pointer and stage-1 register
    logic [CW-1:0] rr_ptr;
    logic          s1_valid;
    logic [CW-1:0] s1_ch;
    logic [DW-1:0] s1_sample;
    logic [DW-1:0] s1_old;

    logic            s1_adv;
    logic            advance;
    logic            grant_en;
    logic            grant_any;
    logic [N_CH-1:0] s1_occ;
    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] rotated;
    logic [CW:0]     pick;
    logic [CW-1:0]   grant_ch;
    logic [SW-1:0]   new_sum;
    logic [DW-1:0]   avg;
    logic            present;

    // S1 may move into the output register when the register is empty or is draining this cycle
    assign s1_adv   = !out_valid || out_ready;
    assign advance  = s1_valid && s1_adv;
    // A new grant needs S1 to be free by the next edge; rst_n gating keeps in_ready low during reset
    assign grant_en = rst_n && (!s1_valid || s1_adv);

    // The channel sitting in S1 is not eligible, so one channel is never granted on two consecutive cycles
    assign s1_occ   = s1_valid ? (N_CH'(1) << s1_ch) : '0;
    assign eligible = in_valid & ~ch_clear & ~s1_occ;
    // Bit i of rotated is channel (rr_ptr + i) mod N_CH
    assign rotated  = N_CH'({eligible, eligible} >> rr_ptr);

    // Round-robin pick: the lowest rotated offset wins, then map the offset back to a channel number
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pick      = '0;
        grant_ch  = '0;
        grant_any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rotated[i]) pick = {1'b0, rr_ptr} + (CW+1)'(i);
        end
        if (pick >= (CW+1)'(N_CH)) pick = pick - (CW+1)'(N_CH);
        grant_ch  = pick[CW-1:0];
        grant_any = grant_en && (|rotated);
    end

    assign in_ready = grant_any ? (N_CH'(1) << grant_ch) : '0;

    // Old slot value always lies inside the current sum, so the subtraction cannot underflow
    assign new_sum = sum[s1_ch] + SW'(s1_sample) - SW'(s1_old);
    assign avg     = DW'(new_sum / SW'(WINDOW));

`ifdef WARMUP_MASK_EN
    localparam int FW = $clog2(WINDOW + 1);
    logic [FW-1:0] fill [N_CH];

    assign present = (fill[s1_ch] >= FW'(WINDOW - 1));

    // Fill counter, saturating at WINDOW; cleared together with the channel history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) fill[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_clear[c]) fill[c] <= '0;
                else if (advance && s1_ch == CW'(c) && fill[c] != FW'(WINDOW)) fill[c] <= fill[c] + 1'b1;
            end
        end
    end
`else
    assign present = 1'b1;
`endif

    // Arbiter pointer, stage-1 capture and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so every block reads pre-edge values.
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_sample <= '0;
            s1_old    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            if (grant_any) begin
                s1_valid  <= 1'b1;
                s1_ch     <= grant_ch;
                s1_sample <= in_data[int'(grant_ch)*DW +: DW];
                s1_old    <= hist[grant_ch][wptr[grant_ch]];
                rr_ptr    <= (grant_ch == CW'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end else if (s1_valid && ch_clear[s1_ch]) begin
                // The history was cleared under a stalled entry: its old slot is now zero
                s1_old <= '0;
            end

            if (advance) begin
                out_valid <= present;
                if (present) begin
                    out_data <= avg;
                    out_ch   <= s1_ch;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Per-channel history, sum and write pointer; a clear wins over a same-edge commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the history array is reset explicitly because warm-up averages depend on it starting at zero.
            for (int c = 0; c < N_CH; c++) begin
                for (int w = 0; w < WINDOW; w++) hist[c][w] <= '0;
                sum[c]  <= '0;
                wptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_clear[c]) begin
                    for (int w = 0; w < WINDOW; w++) hist[c][w] <= '0;
                    sum[c]  <= '0;
                    wptr[c] <= '0;
                end else if (advance && s1_ch == CW'(c)) begin
                    hist[c][wptr[c]] <= s1_sample;
                    sum[c]           <= new_sum;
                    wptr[c]          <= (wptr[c] == PW'(WINDOW - 1)) ? '0 : wptr[c] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Directed bench for filter_channel_scheduler in its default build (N_CH=4, DW=14, WINDOW=7).
module tb_filter_channel_scheduler;

    localparam int N_CH   = 4;
    localparam int DW     = 14;
    localparam int WINDOW = 7;
    localparam int CW     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH*DW-1:0]   in_data;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0]      in_ready;
    logic [N_CH-1:0]      ch_clear;
    logic [DW-1:0]        out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    filter_channel_scheduler #(.N_CH(N_CH), .DW(DW), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ch_clear(ch_clear), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Offer one sample, wait (bounded) for its grant, then expect the result exactly two edges later
    task automatic send_one(input int ch, input int data, input int exp, input string name);
        int n = 0;
        @(negedge clk);
        in_data[ch*DW +: DW] = DW'(data);
        in_valid[ch] = 1'b1;
        #1;
        while (!in_ready[ch] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (!in_ready[ch]) begin
            $display("FAIL %s_grant: in_ready=%b, want bit %0d within 20 cycles", name, in_ready, ch);
            fails++;
            in_valid[ch] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL %s_latency: out_valid=%b one cycle after accept, want 0", name, out_valid);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(exp) || out_ch !== CW'(ch)) begin
            $display("FAIL %s_result: valid=%b data=%0d ch=%0d, want valid=1 data=%0d ch=%0d",
                     name, out_valid, out_data, out_ch, exp, ch);
            fails++;
        end
    endtask

    task automatic clear_chans(input logic [N_CH-1:0] mask);
        @(negedge clk);
        ch_clear = mask;
        @(negedge clk);
        ch_clear = '0;
    endtask

    task automatic test_reset();
        in_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || in_ready !== '0) begin
            $display("FAIL reset_outputs: valid=%b data=%0d ch=%0d ready=%b, want all 0",
                     out_valid, out_data, out_ch, in_ready);
            fails++;
        end
        // Release, put one ch1 sample into S1, then reset before it commits
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b0010;
        in_data[1*DW +: DW] = DW'(500);
        @(posedge clk);
        #1 in_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || in_ready !== '0) begin
            $display("FAIL reset_midstream: valid=%b data=%0d ch=%0d ready=%b, want all 0",
                     out_valid, out_data, out_ch, in_ready);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                $display("FAIL reset_discard: out_valid=%b in cycle %0d after release, want 0", out_valid, k);
                fails++;
            end
        end
        // Discarded 500 must not appear in ch1 history: 700/7 = 100, not 1200/7
        send_one(1, 700, 100, "reset_ch1");
        send_one(0, 700, 100, "reset_ch0");
    endtask

    // ch0 samples 7k: the k-th result averages the last min(k,7) samples over 7 -> sum of j
    task automatic test_window_wrap();
        int exp;
        clear_chans(4'b0001);
        for (int k = 1; k <= 10; k++) begin
            exp = 0;
            for (int j = (k > 6 ? k - 6 : 1); j <= k; j++) exp += j;
            send_one(0, 7 * k, exp, $sformatf("wrap_%0d", k));
        end
    endtask

    // All four channels hold data c*70; the pointer sits at 1 after the last ch0 grant
    task automatic test_round_robin();
        int cnt [N_CH];
        int exp_ch [8];
        int exp_data [8];
        int g;
        clear_chans('1);
        for (int c = 0; c < N_CH; c++) begin
            in_data[c*DW +: DW] = DW'(c * 70);
            cnt[c] = 0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i < 8) ? '1 : '0;
            #1;
            if (i < 8) begin
                g = (1 + i) % N_CH;
                cnt[g]++;
                exp_ch[i]   = g;
                exp_data[i] = cnt[g] * g * 10;
                tests++;
                if (in_ready !== (N_CH'(1) << g)) begin
                    $display("FAIL rr_grant_%0d: in_ready=%b, want ch %0d", i, in_ready, g);
                    fails++;
                end
            end
            if (i >= 2) begin
                tests++;
                if (out_valid !== 1'b1 || out_ch !== CW'(exp_ch[i-2]) || out_data !== DW'(exp_data[i-2])) begin
                    $display("FAIL rr_result_%0d: valid=%b ch=%0d data=%0d, want valid=1 ch=%0d data=%0d",
                             i - 2, out_valid, out_ch, out_data, exp_ch[i-2], exp_data[i-2]);
                    fails++;
                end
            end
        end
    endtask

    // A lone continuously valid channel is accepted only every other cycle
    task automatic test_single_channel();
        in_data[2*DW +: DW] = DW'(70);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 4'b0100;
            #1;
            tests++;
            if (in_ready !== ((i % 2 == 0) ? 4'b0100 : 4'b0000)) begin
                $display("FAIL single_ready_%0d: in_ready=%b, want %b", i, in_ready,
                         (i % 2 == 0) ? 4'b0100 : 4'b0000);
                fails++;
            end
        end
        @(negedge clk);
        in_valid = '0;
    endtask

    // Pointer at 3: ch0 then ch1 granted; the output stalls and S1 (ch1) blocks everything
    task automatic test_backpressure();
        clear_chans('1);
        @(negedge clk);
        out_ready = 1'b0;
        in_data[0*DW +: DW] = DW'(700);
        in_data[1*DW +: DW] = DW'(1400);
        in_valid = 4'b0011;
        #1;
        tests++;
        if (in_ready !== 4'b0001) begin
            $display("FAIL bp_grant0: in_ready=%b, want 0001", in_ready);
            fails++;
        end
        @(negedge clk);
        in_valid = 4'b0010;
        #1;
        tests++;
        if (in_ready !== 4'b0010) begin
            $display("FAIL bp_grant1: in_ready=%b, want 0010", in_ready);
            fails++;
        end
        @(negedge clk);
        in_data[3*DW +: DW] = DW'(2100);
        in_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (in_ready !== '0 || out_valid !== 1'b1 || out_data !== DW'(100) || out_ch !== CW'(0)) begin
                $display("FAIL bp_stall_%0d: ready=%b valid=%b data=%0d ch=%0d, want ready=0000 valid=1 data=100 ch=0",
                         k, in_ready, out_valid, out_data, out_ch);
                fails++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 4'b1000) begin
            $display("FAIL bp_release_grant: in_ready=%b, want 1000", in_ready);
            fails++;
        end
        @(negedge clk);
        in_valid = '0;
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(200) || out_ch !== CW'(1)) begin
            $display("FAIL bp_drain_ch1: valid=%b data=%0d ch=%0d, want valid=1 data=200 ch=1",
                     out_valid, out_data, out_ch);
            fails++;
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(300) || out_ch !== CW'(3)) begin
            $display("FAIL bp_drain_ch3: valid=%b data=%0d ch=%0d, want valid=1 data=300 ch=3",
                     out_valid, out_data, out_ch);
            fails++;
        end
        @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_empty: out_valid=%b, want 0", out_valid);
            fails++;
        end
    endtask

    // ch2 holds 350; clearing it makes the next 700 average to 100 instead of 150
    task automatic test_clear();
        send_one(2, 350, 50, "clr_pre");
        @(negedge clk);
        in_data[2*DW +: DW] = DW'(700);
        in_valid = 4'b0100;
        ch_clear = 4'b0100;
        #1;
        tests++;
        if (in_ready !== '0) begin
            $display("FAIL clr_block: in_ready=%b while ch_clear[2]=1, want 0000", in_ready);
            fails++;
        end
        @(negedge clk);
        ch_clear = '0;
        in_valid = '0;
        send_one(2, 700, 100, "clr_post");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        ch_clear  = '0;
        out_ready = 1'b1;
        test_reset();
        test_window_wrap();
        test_round_robin();
        test_single_channel();
        test_backpressure();
        test_clear();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
